// File: rtl/fp_normalizer.sv
// fp_normalizer: post-add normalization stage for a single-precision FP adder.
// Accepts the adder's raw sign/exponent/25-bit mantissa sum and renormalizes it:
// one right shift on carry-out, or iterative left shifts (one per cycle) after
// cancellation. Handles zero, overflow to infinity and flush-to-zero underflow,
// and presents a packed IEEE 754 word with flags {inexact, overflow, underflow, zero}.
// Build option: define FPN_ROUND_EN for round-to-nearest-even on the carry path;
// without it the bit dropped by the right shift is truncated.
module fp_normalizer #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sign,
    input  logic [EXP_W-1:0]         in_exp,
    input  logic [FRAC_W+1:0]        in_mant,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+FRAC_W:0]    out_result,
    output logic [3:0]               out_flags
);

    localparam int MANT_W = FRAC_W + 2;
    localparam int RES_W  = 1 + EXP_W + FRAC_W;
    localparam int CNT_W  = $clog2(FRAC_W + 1);

    localparam logic [EXP_W-1:0]  EXP_ONES = '1;
    localparam logic [EXP_W-1:0]  EXP_ZERO = '0;
    localparam logic [FRAC_W-1:0] FRAC_ZERO = '0;

    localparam logic [3:0] F_ZERO = 4'b0001;
    localparam logic [3:0] F_UNF  = 4'b0010;
    localparam logic [3:0] F_OVF  = 4'b0100;
    localparam logic [3:0] F_INX  = 4'b1000;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t state, state_nx;

    // Working operands carried through the left-shift loop (carry bit is
    // always clear once we are shifting left, so it is not kept).
    logic              sign_r;
    logic [EXP_W-1:0]  exp_r;
    logic [FRAC_W:0]   mant_r;
    logic [CNT_W-1:0]  cnt;

    logic              accept;
    logic              round_up;
    logic [FRAC_W:0]   frac_sum;
    logic [EXP_W:0]    carry_exp;
    logic [RES_W-1:0]  cls_result;
    logic [3:0]        cls_flags;
    logic              cls_shift;

    logic [FRAC_W:0]   sh_mant;
    logic [EXP_W-1:0]  sh_exp;
    logic              sh_flush;
    logic              sh_norm;

    function automatic logic [RES_W-1:0] pack(input logic s,
                                              input logic [EXP_W-1:0] e,
                                              input logic [FRAC_W-1:0] f);
        return {s, e, f};
    endfunction

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // Single-cycle classification of the incoming raw sum, in priority order.
    always_comb begin
        cls_result = '0;
        cls_flags  = '0;
        cls_shift  = 1'b0;
`ifdef FPN_ROUND_EN
        // Guard is the bit shifted out, lsb is the bit that becomes frac[0].
        round_up = in_mant[0] & in_mant[1];
`else
        round_up = 1'b0;
`endif
        frac_sum  = {1'b0, in_mant[FRAC_W:1]} + {{FRAC_W{1'b0}}, round_up};
        // A fraction rounding out of all-ones bumps the exponent a second time.
        carry_exp = {1'b0, in_exp} + (EXP_W+1)'(1) + {{EXP_W{1'b0}}, frac_sum[FRAC_W]};

        if (in_exp == EXP_ONES) begin
            cls_result = pack(in_sign, EXP_ONES, FRAC_ZERO);
            cls_flags  = F_OVF;
        end else if (in_mant == '0) begin
            cls_result = '0;
            cls_flags  = F_ZERO;
        end else if (in_mant[MANT_W-1]) begin
            if (carry_exp >= {1'b0, EXP_ONES}) begin
                cls_result = pack(in_sign, EXP_ONES, FRAC_ZERO);
                cls_flags  = F_OVF;
            end else begin
                cls_result = pack(in_sign, carry_exp[EXP_W-1:0], frac_sum[FRAC_W-1:0]);
            end
            if (in_mant[0]) begin
                cls_flags = cls_flags | F_INX;
            end
        end else if (in_mant[FRAC_W]) begin
            cls_result = pack(in_sign, in_exp, in_mant[FRAC_W-1:0]);
        end else if (in_exp == EXP_ZERO) begin
            cls_result = pack(in_sign, EXP_ZERO, FRAC_ZERO);
            cls_flags  = F_UNF | F_INX;
        end else begin
            cls_shift = 1'b1;
        end
    end

    // One left-shift step; the step either flushes, normalizes or repeats.
    always_comb begin
        sh_mant  = mant_r << 1;
        sh_exp   = exp_r - EXP_W'(1);
        sh_flush = (sh_exp == EXP_ZERO);
        sh_norm  = sh_mant[FRAC_W];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = cls_shift ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (sh_flush || sh_norm) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Working operand registers: loaded on accept, stepped while shifting.
    always_ff @(posedge clk) begin
        if (state == IDLE && accept) begin
            sign_r <= in_sign;
            exp_r  <= in_exp;
            mant_r <= in_mant[FRAC_W:0];
        end else if (state == SHIFT) begin
            exp_r  <= sh_exp;
            mant_r <= sh_mant;
        end
    end

    // Output word, flags and shift counter; written on DONE entry only.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_result <= '0;
            out_flags  <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt <= '0;
                        if (!cls_shift) begin
                            out_result <= cls_result;
                            out_flags  <= cls_flags;
                        end
                    end
                end
                SHIFT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (sh_flush) begin
                        out_result <= pack(sign_r, EXP_ZERO, FRAC_ZERO);
                        out_flags  <= F_UNF | F_INX;
                    end else if (sh_norm) begin
                        out_result <= pack(sign_r, sh_exp, sh_mant[FRAC_W-1:0]);
                        out_flags  <= '0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_flags <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_normalizer.sv
// Testbench for fp_normalizer: table of directed vectors with hand-computed
// results, plus sequences for reset, output back-pressure and mid-shift reset.
// Expected values follow the FPN_ROUND_EN build option when it is defined.
module tb_fp_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    int n_vec = 0;
    int n_err = 0;

    fp_normalizer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [24:0] mant;
        logic [31:0] res;
        logic [3:0]  flags;
        int          lat;
    } vec_t;

`ifdef FPN_ROUND_EN
    localparam logic [31:0] R_RND1  = 32'h40000002;
    localparam logic [31:0] R_RND2  = 32'h41000000;
    localparam logic [31:0] R_RND3  = 32'h7F800000;
    localparam logic [3:0]  F_RND3  = 4'b1100;
`else
    localparam logic [31:0] R_RND1  = 32'h40000001;
    localparam logic [31:0] R_RND2  = 32'h40FFFFFF;
    localparam logic [31:0] R_RND3  = 32'h7F7FFFFF;
    localparam logic [3:0]  F_RND3  = 4'b1000;
`endif

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present one operand, wait for the result, check it, then hand it off.
    task automatic apply(input vec_t v, input int idx);
        int lat;
        int guard;
        n_vec++;
        @(negedge clk);
        in_sign  = v.sign;
        in_exp   = v.exp;
        in_mant  = v.mant;
        in_valid = 1'b1;
        out_ready = 1'b0;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'd1);
        check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
        check($sformatf("v%0d result", idx), out_result, v.res);
        check($sformatf("v%0d flags", idx), 32'(out_flags), 32'(v.flags));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check($sformatf("v%0d handoff out_valid", idx), 32'(out_valid), 32'd0);
        check($sformatf("v%0d handoff in_ready", idx), 32'(in_ready), 32'd1);
        check($sformatf("v%0d flags cleared", idx), 32'(out_flags), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 8'h7F, 25'h0C00000, 32'h3FC00000, 4'b0000, 1};
        vecs[1]  = '{1'b0, 8'h7F, 25'h1800000, 32'h40400000, 4'b0000, 1};
        vecs[2]  = '{1'b0, 8'h7F, 25'h1000003, R_RND1,       4'b1000, 1};
        vecs[3]  = '{1'b0, 8'h80, 25'h0200000, 32'h3F000000, 4'b0000, 3};
        vecs[4]  = '{1'b0, 8'h02, 25'h0200000, 32'h00000000, 4'b1010, 3};
        vecs[5]  = '{1'b1, 8'h55, 25'h0000000, 32'h00000000, 4'b0001, 1};
        vecs[6]  = '{1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 4'b0100, 1};
        vecs[7]  = '{1'b1, 8'hFF, 25'h0C00000, 32'hFF800000, 4'b0100, 1};
        vecs[8]  = '{1'b1, 8'h00, 25'h0400000, 32'h80000000, 4'b1010, 1};
        vecs[9]  = '{1'b0, 8'h7F, 25'h0000001, 32'h34000000, 4'b0000, 24};
        vecs[10] = '{1'b0, 8'h80, 25'h1FFFFFF, R_RND2,       4'b1000, 1};
        vecs[11] = '{1'b0, 8'hFE, 25'h1000001, 32'h7F800000, 4'b1100, 1};
        vecs[12] = '{1'b0, 8'hFD, 25'h1FFFFFF, R_RND3,       F_RND3,  1};

        rst = 1'b1;
        in_valid = 1'b0;
        in_sign = 1'b0;
        in_exp = '0;
        in_mant = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", out_result, 32'd0);
        check("reset flags", 32'(out_flags), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-reset in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 13; i++) begin
            apply(vecs[i], i);
        end

        // Back-pressure: hold DONE for 5 cycles while a new input waits.
        n_vec++;
        @(negedge clk);
        in_sign = 1'b1;
        in_exp = 8'h7F;
        in_mant = 25'h1800001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_exp = 8'h10;
        in_mant = 25'h0C00000;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("hold%0d out_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("hold%0d in_ready", c), 32'(in_ready), 32'd0);
            check($sformatf("hold%0d result", c), out_result, 32'hC0400000);
            check($sformatf("hold%0d flags", c), 32'(out_flags), 32'h8);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("hold release out_valid", 32'(out_valid), 32'd0);
        check("hold release in_ready", 32'(in_ready), 32'd1);

        // Reset pulse in the middle of a long shift sequence.
        n_vec++;
        @(negedge clk);
        in_sign = 1'b0;
        in_exp = 8'h7F;
        in_mant = 25'h0000001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("shift in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid-shift rst out_valid", 32'(out_valid), 32'd0);
        check("mid-shift rst in_ready", 32'(in_ready), 32'd1);
        repeat (30) @(posedge clk);
        #1;
        check("mid-shift rst no output", 32'(out_valid), 32'd0);
        apply(vecs[0], 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fp_normalizer.md
Name: fp_normalizer

Overview:
Sequential post-add normalization stage that sits directly downstream of the combinational FP adder. It takes the adder's raw sign, exponent and 25-bit mantissa sum over a valid/ready handshake. It renormalizes the mantissa: one right shift on carry-out, or iterative left shifts (one per cycle) after cancellation. It handles zero, overflow to infinity and underflow flush-to-zero, then presents a packed IEEE 754 single-precision word with status flags.

Parameters:
EXP_W, 8, exponent field width
FRAC_W, 23, stored fraction width (mantissa input is FRAC_W+2 bits: carry, hidden, fraction)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  raw sum available
in_ready  output  1  block can accept; = (state==IDLE) && !rst
in_sign  input  1  raw result sign
in_exp  input  EXP_W  raw result exponent (biased)
in_mant  input  FRAC_W+2  raw magnitude; bit 24 carry, bit 23 hidden
out_valid  output  1  packed result valid
out_ready  input  1  consumer accepts result
out_result  output  32  packed {sign, exp, frac}
out_flags  output  4  [0] zero, [1] underflow, [2] overflow, [3] inexact

Behaviour:
- Reset: state IDLE; out_valid=0, out_result=0, out_flags=0, shift counter=0; in_ready=0 while rst is high, 1 on the first cycle after.
- States: IDLE, SHIFT, DONE. in_ready is high only in IDLE. out_valid is high only in DONE.
- IDLE, accept on in_valid&&in_ready. At that edge, classify the input in this priority order:
  - in_exp==all-ones: result {in_sign, FF, 0}; overflow=1; go to DONE.
  - in_mant==0: result forced to +0 (32'h00000000); zero=1; go to DONE.
  - in_mant[24]=1: mant>>1, exp+1. If exp+1==FF: result {sign, FF, 0}, overflow=1. Inexact=in_mant[0]. Without rounding the dropped bit is truncated. Go to DONE.
  - in_mant[23]=1: pack {sign, exp, mant[22:0]}; go to DONE. Latency 1.
  - in_exp==0 with unnormalized mantissa: result {sign, 0, 0}; underflow=1; inexact=1; go to DONE.
  - Otherwise: latch the operands; go to SHIFT.
- SHIFT, each edge: new_mant=mant<<1, new_exp=exp-1, counter+1.
  - new_exp==0: flush to {sign, 0, 0}; underflow=1; inexact=1; go to DONE.
  - else new_mant[23]=1: pack; go to DONE.
  - else: stay in SHIFT.
  - Counter never exceeds 23.
- Latency: k left shifts means out_valid rises 1+k cycles after the accept edge. Maximum is 24.
- DONE: out_result and out_flags stay stable while out_valid && !out_ready. On out_ready, the next edge returns to IDLE and clears out_valid. A new input is not accepted in the same cycle as output handoff, so throughput is one result per 2+k cycles.
- Subnormal outputs are not produced; results are flushed to signed zero instead.
- Flags are written only at DONE entry and cleared at IDLE re-entry.
- rst mid-SHIFT or mid-DONE: the in-flight operation is discarded and no output is produced. The next cycle shows IDLE state, out_valid=0 and in_ready=1.
- in_valid during SHIFT or DONE is ignored. The upstream stage holds its data until in_ready is seen.

Optional Feature:
FPN_ROUND_EN
- Defined: round-to-nearest-even on the carry path.
  - guard = in_mant[0], lsb = in_mant[1].
  - Round up when guard && lsb.
  - If the fraction rounds from all-ones, clear it and add 1 to exp; exp reaching FF gives infinity with overflow=1.
  - Rounding adds no latency.
- Undefined: the dropped bit is truncated.
- Inexact flag behaviour is identical in both builds.

Test Plan:
1. in_sign=0, in_exp=0x7F, in_mant=25'h0C00000 -> out_result=0x3FC00000, flags=0, out_valid 1 cycle after accept.
2. in_exp=0x7F, in_mant=25'h1800000 -> out_result=0x40400000, flags=0. With in_mant=25'h1000003: FPN_ROUND_EN gives 0x40000002, undefined gives 0x40000001; inexact=1 in both builds.
3. in_exp=0x80, in_mant=25'h0200000 -> 2 shifts, out_result=0x3F000000, out_valid 3 cycles after accept. Same operand with in_exp=0x02 -> out_result=0x00000000, underflow=1, inexact=1.
4. in_sign=1, in_mant=0 -> out_result=0x00000000, zero=1, latency 1.
5. in_exp=0xFE, in_mant=25'h1000000 -> out_result=0x7F800000, overflow=1.
6. Hold out_ready=0 for 5 cycles in DONE -> result and flags stable, in_ready=0. Separately, pulse rst during SHIFT -> next cycle out_valid=0, in_ready=1, and a subsequent test-1 input completes correctly.
